// File: rtl/sync_updown_counter.sv
// Parametrised synchronous up/down counter with parallel load, wrap/saturate
// mode and a combinational terminal-count output for tc -> en cascading.
module sync_updown_counter #(
    parameter int     WIDTH     = 4,
    parameter longint MODULUS   = 16,
    parameter longint RESET_VAL = 0,
    parameter bit     SATURATE  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap_p,
    output logic             at_limit
);

    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_VAL  = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] ZERO_VAL = '0;
    localparam logic [WIDTH-1:0] ONE_VAL  = WIDTH'(1);

    // Parameter sanity is enforced while elaborating, never at run time.
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("sync_updown_counter: WIDTH must be in 1..32");
    end
    if (MODULUS < 2 || MODULUS > (longint'(1) << WIDTH)) begin : g_bad_modulus
        $error("sync_updown_counter: MODULUS must be in 2..2**WIDTH");
    end
    if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_reset_val
        $error("sync_updown_counter: RESET_VAL must be below MODULUS");
    end

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_p_q, wrap_p_d;

    always_comb begin
        count_d  = count_q;
        wrap_p_d = 1'b0;
        if (load) begin
            count_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end else if (en) begin
            if (up) begin
                if (count_q != MAX_VAL) begin
                    count_d = count_q + ONE_VAL;
                end else if (!SATURATE) begin
                    count_d  = ZERO_VAL;
                    wrap_p_d = 1'b1;
                end
            end else begin
                if (count_q != ZERO_VAL) begin
                    count_d = count_q - ONE_VAL;
                end else if (!SATURATE) begin
                    count_d  = MAX_VAL;
                    wrap_p_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= RST_VAL;
            wrap_p_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            wrap_p_q <= wrap_p_d;
        end
    end

    // tc is only meaningful when this edge really steps the counter past its bound.
    assign at_limit = up ? (count_q == MAX_VAL) : (count_q == ZERO_VAL);
    assign tc       = en && at_limit && !load && !reset;
    assign count    = count_q;
    assign wrap_p   = wrap_p_q;

endmodule

// File: tb/tb_sync_updown_counter.sv
// Directed bench for sync_updown_counter: default, MODULUS=10, saturating and
// cascaded two-digit decade instances sharing one clock.
module tb_sync_updown_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // default instance
    logic       d_reset, d_en, d_up, d_load, d_tc, d_wrap, d_lim;
    logic [3:0] d_lval, d_count;
    sync_updown_counter u_dflt (
        .clk(clk), .reset(d_reset), .en(d_en), .up(d_up), .load(d_load),
        .load_val(d_lval), .count(d_count), .tc(d_tc), .wrap_p(d_wrap), .at_limit(d_lim)
    );

    // MODULUS=10 instance
    logic       m_reset, m_en, m_up, m_load, m_tc, m_wrap, m_lim;
    logic [3:0] m_lval, m_count;
    sync_updown_counter #(.MODULUS(10)) u_mod10 (
        .clk(clk), .reset(m_reset), .en(m_en), .up(m_up), .load(m_load),
        .load_val(m_lval), .count(m_count), .tc(m_tc), .wrap_p(m_wrap), .at_limit(m_lim)
    );

    // saturating instance
    logic       s_reset, s_en, s_up, s_load, s_tc, s_wrap, s_lim;
    logic [3:0] s_lval, s_count;
    sync_updown_counter #(.SATURATE(1'b1)) u_sat (
        .clk(clk), .reset(s_reset), .en(s_en), .up(s_up), .load(s_load),
        .load_val(s_lval), .count(s_count), .tc(s_tc), .wrap_p(s_wrap), .at_limit(s_lim)
    );

    // cascaded decade pair: hi.en <= lo.tc
    logic       c_reset, c_en, c_load;
    logic       lo_tc, lo_wrap, lo_lim, hi_tc, hi_wrap, hi_lim;
    logic [3:0] c_lval, lo_count, hi_count;
    sync_updown_counter #(.MODULUS(10)) u_lo (
        .clk(clk), .reset(c_reset), .en(c_en), .up(1'b1), .load(c_load),
        .load_val(c_lval), .count(lo_count), .tc(lo_tc), .wrap_p(lo_wrap), .at_limit(lo_lim)
    );
    sync_updown_counter #(.MODULUS(10)) u_hi (
        .clk(clk), .reset(c_reset), .en(lo_tc), .up(1'b1), .load(c_load),
        .load_val(c_lval), .count(hi_count), .tc(hi_tc), .wrap_p(hi_wrap), .at_limit(hi_lim)
    );

    task automatic edge_settle();
        @(posedge clk);
        #1;
    endtask

    int cur;

    initial begin
        d_reset = 1; d_en = 0; d_up = 0; d_load = 0; d_lval = 0;
        m_reset = 1; m_en = 0; m_up = 1; m_load = 0; m_lval = 0;
        s_reset = 1; s_en = 0; s_up = 1; s_load = 0; s_lval = 0;
        c_reset = 1; c_en = 0; c_load = 0; c_lval = 0;
        repeat (2) edge_settle();

        check_eq("rst_d_count", 32'(d_count), 0);
        check_eq("rst_d_wrap",  32'(d_wrap), 0);
        check_eq("rst_m_count", 32'(m_count), 0);
        check_eq("rst_s_count", 32'(s_count), 0);

        // 1: default, count down 17 edges
        d_reset = 0; d_en = 1; d_up = 0;
        cur = 0;
        for (int k = 1; k <= 17; k++) begin
            #1;
            check_eq($sformatf("t1_tc_%0d", k), 32'(d_tc), 32'(cur == 0));
            check_eq($sformatf("t1_lim_%0d", k), 32'(d_lim), 32'(cur == 0));
            edge_settle();
            cur = (cur == 0) ? 15 : cur - 1;
            check_eq($sformatf("t1_cnt_%0d", k), 32'(d_count), 32'(cur));
            check_eq($sformatf("t1_wrap_%0d", k), 32'(d_wrap), 32'(k == 1 || k == 17));
            $display("t1 edge %0d count=%0d wrap_p=%0d", k, d_count, d_wrap);
        end
        d_en = 0;

        // 2: MODULUS=10 counting up
        m_reset = 0; m_en = 1; m_up = 1;
        cur = 0;
        for (int k = 1; k <= 12; k++) begin
            #1;
            check_eq($sformatf("t2_tc_%0d", k), 32'(m_tc), 32'(cur == 9));
            edge_settle();
            cur = (cur == 9) ? 0 : cur + 1;
            check_eq($sformatf("t2_cnt_%0d", k), 32'(m_count), 32'(cur));
            check_eq($sformatf("t2_wrap_%0d", k), 32'(m_wrap), 32'(k == 10));
            $display("t2 edge %0d count=%0d wrap_p=%0d", k, m_count, m_wrap);
        end
        m_en = 0;

        // 3: saturating up, then reverse
        s_reset = 0; s_en = 1; s_up = 1;
        for (int k = 1; k <= 20; k++) begin
            #1;
            check_eq($sformatf("t3_tc_%0d", k), 32'(s_tc), 32'(k >= 16));
            edge_settle();
            check_eq($sformatf("t3_cnt_%0d", k), 32'(s_count), (k < 15) ? 32'(k) : 32'd15);
            check_eq($sformatf("t3_wrap_%0d", k), 32'(s_wrap), 0);
        end
        $display("t3 saturated count=%0d", s_count);
        s_up = 0;
        edge_settle();
        check_eq("t3_reverse", 32'(s_count), 14);
        $display("t3 reverse count=%0d", s_count);
        s_en = 0;

        // 4: loads
        d_en = 1; d_up = 0; d_load = 1; d_lval = 7;
        #1;
        check_eq("t4_tc_masked_by_load", 32'(d_tc), 0);
        edge_settle();
        check_eq("t4_load7", 32'(d_count), 7);
        check_eq("t4_load_wrap", 32'(d_wrap), 0);
        $display("t4 load 7 -> count=%0d", d_count);
        m_load = 1; m_lval = 12;
        edge_settle();
        check_eq("t4_clamp", 32'(m_count), 9);
        $display("t4 load 12 mod10 -> count=%0d", m_count);
        m_load = 0;
        d_lval = 5; d_reset = 1;
        edge_settle();
        check_eq("t4_load_rst", 32'(d_count), 0);
        $display("t4 load+reset -> count=%0d", d_count);
        d_reset = 0;

        // 5: en toggling from 3, up
        d_lval = 3; d_en = 0; d_up = 1;
        edge_settle();
        d_load = 0;
        check_eq("t5_start", 32'(d_count), 3);
        begin
            logic [3:0] en_pat;
            logic [3:0] exp_cnt;
            en_pat  = 4'b1001;
            exp_cnt = 4'd3;
            for (int k = 3; k >= 0; k--) begin
                d_en = en_pat[k];
                edge_settle();
                if (en_pat[k]) exp_cnt = exp_cnt + 4'd1;
                check_eq($sformatf("t5_cnt_%0d", 3 - k), 32'(d_count), 32'(exp_cnt));
                check_eq($sformatf("t5_wrap_%0d", 3 - k), 32'(d_wrap), 0);
                $display("t5 en=%0d count=%0d", d_en, d_count);
            end
        end
        d_load = 1; d_lval = 11; d_en = 1;
        edge_settle();
        d_load = 0;
        edge_settle();
        check_eq("t5_at12", 32'(d_count), 12);
        d_reset = 1;
        #1;
        check_eq("t5_tc_masked_by_reset", 32'(d_tc), 0);
        edge_settle();
        check_eq("t5_reset_mid", 32'(d_count), 0);
        $display("t5 reset at 12 -> count=%0d", d_count);
        d_reset = 0; d_en = 0;

        // 6: cascaded decades
        c_reset = 0; c_en = 1;
        for (int k = 1; k <= 100; k++) begin
            edge_settle();
            check_eq($sformatf("t6_lo_%0d", k), 32'(lo_count), 32'(k % 10));
            check_eq($sformatf("t6_hi_%0d", k), 32'(hi_count), 32'((k / 10) % 10));
            check_eq($sformatf("t6_hiwrap_%0d", k), 32'(hi_wrap), 32'(k == 100));
            if (k % 10 == 0) $display("t6 edge %0d hi=%0d lo=%0d hi_wrap=%0d", k, hi_count, lo_count, hi_wrap);
        end
        c_en = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
